// File: rtl/tdc_pkg.sv
// Shared types for the TDC frame controller.
// Contents:
//   TOF_W, INT_W  - tof (coarse 10b + fine 5b) and intensity widths
//   fsm_state_t   - frame sequencer states
//   slot_t        - one result slot {valid, tof, intensity}
package tdc_pkg;

  localparam int TOF_W = 15;
  localparam int INT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WINDOW,
    DRAIN,
    DONE
  } fsm_state_t;

  typedef struct packed {
    logic             valid;
    logic [TOF_W-1:0] tof;
    logic [INT_W-1:0] intensity;
  } slot_t;

endpackage

// File: rtl/tdc_topn_buf.sv
// Keeps the DEPTH strongest (tof, intensity) results of one frame.
// Ports:
//   clk, rst      logic clock, async active-high reset
//   i_clear       invalidate every slot (frame start)
//   i_ins         offer a hit to the buffer this cycle
//   i_tof, i_int  the offered hit
//   i_rd_idx      read port index
//   o_rd_slot     slot at i_rd_idx
//   o_count_nxt   number of valid slots after this cycle's insert
// Empty slots are always filled lowest-first and are never emptied inside a
// frame, so valid slots occupy indices 0..count-1.
module tdc_topn_buf
  import tdc_pkg::*;
#(
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_ins,
  input  logic [TOF_W-1:0] i_tof,
  input  logic [INT_W-1:0] i_int,
  input  logic [CNT_W-1:0] i_rd_idx,
  output slot_t            o_rd_slot,
  output logic [CNT_W-1:0] o_count_nxt
);

  slot_t r_slots [DEPTH];

  logic             w_has_empty;
  logic [CNT_W-1:0] w_empty_idx;
  logic [CNT_W-1:0] w_min_idx;
  logic [INT_W-1:0] w_min_int;
  logic [CNT_W-1:0] w_count;
  logic             w_wr;
  logic [CNT_W-1:0] w_wr_idx;

  always_comb begin
    w_has_empty = 1'b0;
    w_empty_idx = '0;
    // Descending scan so the lowest empty index is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_slots[i].valid) begin
        w_has_empty = 1'b1;
        w_empty_idx = CNT_W'(i);
      end
    end

    // Strict compare keeps the lowest index on intensity ties.
    w_min_idx = '0;
    w_min_int = r_slots[0].intensity;
    for (int i = 1; i < DEPTH; i++) begin
      if (r_slots[i].intensity < w_min_int) begin
        w_min_idx = CNT_W'(i);
        w_min_int = r_slots[i].intensity;
      end
    end

    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + CNT_W'(r_slots[i].valid);
    end

    w_wr        = i_ins & (w_has_empty | (i_int >= w_min_int));
    w_wr_idx    = w_has_empty ? w_empty_idx : w_min_idx;
    o_count_nxt = w_count + CNT_W'(i_ins & w_has_empty);

    o_rd_slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) == i_rd_idx) o_rd_slot = r_slots[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == w_wr_idx) begin
          r_slots[i] <= '{valid: 1'b1, tof: i_tof, intensity: i_int};
        end
      end
    end
  end

endmodule

// File: rtl/tdc_frame_ctrl.sv
// Per-frame sequencer for the TDC datapath: fires the TDC start pulse, opens
// a hit window, keeps the DEPTH strongest hits and streams them out over a
// valid/ready channel, then raises a one-cycle frame interrupt.
// Ports:
//   clk, rst                 logic clock, async active-high reset
//   frame_en                 frames repeat while high
//   window_len               hit-window length (sampled in ARM, 0 acts as 1)
//   min_int                  minimum accepted intensity (TDC_MIN_INT_EN only)
//   hit_valid/tof/int        hit result strobe and payload
//   tdc_start                one-cycle TDC start pulse
//   TDC_Odata/Oint/Olast     output beat payload
//   TDC_Ovalid, TDC_Oready   output handshake
//   TDC_Onum                 valid slot count of the last completed window
//   TDC_INT                  one-cycle frame-complete interrupt
//   busy                     high outside IDLE
// Build option: define TDC_MIN_INT_EN to add min_int and drop weaker hits.
//
// state  | meaning
// IDLE   | waiting for frame_en
// ARM    | start pulse, clear slots, load window counter
// WINDOW | accepting hits until the window counter reaches 1
// DRAIN  | streaming valid slots, lowest index first
// DONE   | interrupt cycle
module tdc_frame_ctrl
  import tdc_pkg::*;
#(
  parameter  int DEPTH = 3,
  parameter  int WIN_W = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_en,
  input  logic [WIN_W-1:0] window_len,
`ifdef TDC_MIN_INT_EN
  input  logic [INT_W-1:0] min_int,
`endif
  input  logic             hit_valid,
  input  logic [TOF_W-1:0] hit_tof,
  input  logic [INT_W-1:0] hit_int,
  output logic             tdc_start,
  output logic [TOF_W-1:0] TDC_Odata,
  output logic [INT_W-1:0] TDC_Oint,
  output logic [CNT_W-1:0] TDC_Onum,
  output logic             TDC_Ovalid,
  output logic             TDC_Olast,
  input  logic             TDC_Oready,
  output logic             TDC_INT,
  output logic             busy
);

  fsm_state_t       r_state;
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_num;
  logic             r_valid;
  logic             r_start;
  logic             r_irq;

  logic             w_ins;
  slot_t            w_rd_slot;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_beat;
  logic             w_last_ptr;

`ifdef TDC_MIN_INT_EN
  assign w_ins = (r_state == WINDOW) & hit_valid & (hit_int >= min_int);
`else
  assign w_ins = (r_state == WINDOW) & hit_valid;
`endif

  tdc_topn_buf #(.DEPTH(DEPTH)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (r_state == ARM),
    .i_ins       (w_ins),
    .i_tof       (hit_tof),
    .i_int       (hit_int),
    .i_rd_idx    (r_ptr),
    .o_rd_slot   (w_rd_slot),
    .o_count_nxt (w_count_nxt)
  );

  assign w_last_ptr = (r_ptr == r_num - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_win_cnt <= '0;
      r_ptr     <= '0;
      r_num     <= '0;
      r_valid   <= 1'b0;
      r_start   <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_irq   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (frame_en) begin
            r_state <= ARM;
            r_start <= 1'b1;
          end
        end
        ARM: begin
          r_win_cnt <= (window_len == '0) ? WIN_W'(1) : window_len;
          r_state   <= WINDOW;
        end
        WINDOW: begin
          r_win_cnt <= r_win_cnt - WIN_W'(1);
          if (r_win_cnt == WIN_W'(1)) begin
            r_num <= w_count_nxt;
            r_ptr <= '0;
            // An empty frame has nothing to stream, so it skips DRAIN.
            if (w_count_nxt == '0) begin
              r_state <= DONE;
              r_irq   <= 1'b1;
            end else begin
              r_state <= DRAIN;
              r_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (TDC_Oready) begin
            if (w_last_ptr) begin
              r_valid <= 1'b0;
              r_state <= DONE;
              r_irq   <= 1'b1;
            end else begin
              r_ptr <= r_ptr + CNT_W'(1);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_beat     = r_valid & w_rd_slot.valid;
  assign tdc_start  = r_start;
  assign TDC_INT    = r_irq;
  assign busy       = (r_state != IDLE);
  assign TDC_Onum   = r_num;
  assign TDC_Ovalid = w_beat;
  assign TDC_Olast  = w_beat & w_last_ptr;
  assign TDC_Odata  = w_beat ? w_rd_slot.tof : '0;
  assign TDC_Oint   = w_beat ? w_rd_slot.intensity : '0;

endmodule

// File: tb/tb_tdc_frame_ctrl.sv
// Bench for tdc_frame_ctrl (DEPTH=3). A list-based reference model of the
// frame sequence is compared against every output on every cycle; directed
// frames add literal expectations for beats, counts and pulse spacing.
module tb_tdc_frame_ctrl;
  import tdc_pkg::*;

  localparam int DEPTH = 3;
  localparam int CNT_W = 2;
  localparam int WIN_W = 16;

  localparam int P_IDLE  = 0;
  localparam int P_ARM   = 1;
  localparam int P_WIN   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic             clk;
  logic             rst;
  logic             frame_en;
  logic [WIN_W-1:0] window_len;
  logic [INT_W-1:0] min_int;
  logic             hit_valid;
  logic [TOF_W-1:0] hit_tof;
  logic [INT_W-1:0] hit_int;
  logic             tdc_start;
  logic [TOF_W-1:0] TDC_Odata;
  logic [INT_W-1:0] TDC_Oint;
  logic [CNT_W-1:0] TDC_Onum;
  logic             TDC_Ovalid;
  logic             TDC_Olast;
  logic             TDC_Oready;
  logic             TDC_INT;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  tdc_frame_ctrl #(.DEPTH(DEPTH), .WIN_W(WIN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_en   (frame_en),
    .window_len (window_len),
`ifdef TDC_MIN_INT_EN
    .min_int    (min_int),
`endif
    .hit_valid  (hit_valid),
    .hit_tof    (hit_tof),
    .hit_int    (hit_int),
    .tdc_start  (tdc_start),
    .TDC_Odata  (TDC_Odata),
    .TDC_Oint   (TDC_Oint),
    .TDC_Onum   (TDC_Onum),
    .TDC_Ovalid (TDC_Ovalid),
    .TDC_Olast  (TDC_Olast),
    .TDC_Oready (TDC_Oready),
    .TDC_INT    (TDC_INT),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  // ---------------- reference model ----------------
  int m_phase = P_IDLE;
  int m_left  = 0;
  int m_beat  = 0;
  int m_num   = 0;
  int m_hit_tof[$];
  int m_hit_int[$];
  int m_slot_tof[$];
  int m_slot_int[$];

  // Apply the keep-the-strongest rule to the frame's accepted hits in order.
  task automatic build_slots();
    m_slot_tof.delete();
    m_slot_int.delete();
    foreach (m_hit_int[h]) begin
      if (m_slot_int.size() < DEPTH) begin
        m_slot_tof.push_back(m_hit_tof[h]);
        m_slot_int.push_back(m_hit_int[h]);
      end else begin
        int mi = 0;
        foreach (m_slot_int[j]) if (m_slot_int[j] < m_slot_int[mi]) mi = j;
        if (m_hit_int[h] >= m_slot_int[mi]) begin
          m_slot_tof[mi] = m_hit_tof[h];
          m_slot_int[mi] = m_hit_int[h];
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE;
      m_left  = 0;
      m_beat  = 0;
      m_num   = 0;
      m_hit_tof.delete();
      m_hit_int.delete();
      m_slot_tof.delete();
      m_slot_int.delete();
    end else begin
      case (m_phase)
        P_IDLE: if (frame_en) m_phase = P_ARM;
        P_ARM: begin
          m_left = (window_len == 0) ? 1 : int'(window_len);
          m_hit_tof.delete();
          m_hit_int.delete();
          m_phase = P_WIN;
        end
        P_WIN: begin
`ifdef TDC_MIN_INT_EN
          if (hit_valid && hit_int >= min_int) begin
`else
          if (hit_valid) begin
`endif
            m_hit_tof.push_back(int'(hit_tof));
            m_hit_int.push_back(int'(hit_int));
          end
          m_left--;
          if (m_left == 0) begin
            build_slots();
            m_num   = m_slot_int.size();
            m_beat  = 0;
            m_phase = (m_num == 0) ? P_DONE : P_DRAIN;
          end
        end
        P_DRAIN: begin
          if (TDC_Oready) begin
            m_beat++;
            if (m_beat == m_num) m_phase = P_DONE;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare + observation ----------------
  int obs_tof[$];
  int obs_int[$];
  int obs_last[$];
  int start_cyc[$];
  int irq_cyc[$];

  initial begin
    forever begin
      logic [26:0] got;
      logic [26:0] exp;
      logic        e_valid;
      logic [TOF_W-1:0] e_tof;
      logic [INT_W-1:0] e_int;
      logic        e_last;
      @(negedge clk);
      cyc++;
      e_valid = (m_phase == P_DRAIN);
      e_tof   = e_valid ? TOF_W'(m_slot_tof[m_beat]) : '0;
      e_int   = e_valid ? INT_W'(m_slot_int[m_beat]) : '0;
      e_last  = e_valid && (m_beat == m_num - 1);
      exp = {m_phase == P_ARM, m_phase == P_DONE, m_phase != P_IDLE, e_valid, e_last,
             CNT_W'(m_num), e_tof, e_int};
      got = {tdc_start, TDC_INT, busy, TDC_Ovalid, TDC_Olast, TDC_Onum, TDC_Odata, TDC_Oint};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle_cmp cyc=%0d {start,int,busy,valid,last,num,data,oint} got=%h exp=%h",
                 cyc, got, exp);
      end
      if (tdc_start) start_cyc.push_back(cyc);
      if (TDC_INT) irq_cyc.push_back(cyc);
      if (TDC_Ovalid && TDC_Oready) begin
        obs_tof.push_back(int'(TDC_Odata));
        obs_int.push_back(int'(TDC_Oint));
        obs_last.push_back(int'(TDC_Olast));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_tof.delete();
    obs_int.delete();
    obs_last.delete();
    start_cyc.delete();
    irq_cyc.delete();
  endtask

  // Returns just after the ARM->WINDOW edge.
  task automatic start_frame(input int wl);
    window_len = WIN_W'(wl);
    frame_en = 1'b1;
    tick(1);
    frame_en = 1'b0;
    tick(1);
  endtask

  task automatic hit(input int tof, input int in);
    hit_valid = 1'b1;
    hit_tof = TOF_W'(tof);
    hit_int = INT_W'(in);
    tick(1);
    hit_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || m_phase != P_IDLE) && n < 60) begin
      tick(1);
      n++;
    end
    chk({name, "_idle_timeout"}, int'(busy), 0);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!TDC_Ovalid && n < 40) begin
      tick(1);
      n++;
    end
    chk({name, "_valid_timeout"}, int'(TDC_Ovalid), 1);
  endtask

  task automatic chk_beat(input string name, input int i, input int tof, input int in, input int last);
    if (obs_tof.size() > i) begin
      chk({name, "_tof"}, obs_tof[i], tof);
      chk({name, "_int"}, obs_int[i], in);
      chk({name, "_last"}, obs_last[i], last);
    end else begin
      chk({name, "_missing"}, obs_tof.size(), i + 1);
    end
  endtask

  function automatic int irq_gap();
    if (start_cyc.size() == 1 && irq_cyc.size() == 1) return irq_cyc[0] - start_cyc[0];
    return -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed frames ----------------
  initial begin
    rst = 1'b0;
    frame_en = 1'b0;
    window_len = '0;
    min_int = '0;
    hit_valid = 1'b0;
    hit_tof = '0;
    hit_int = '0;
    TDC_Oready = 1'b1;
    #1 rst = 1'b1;
    tick(2);
    chk("reset_outputs",
        int'({tdc_start, TDC_INT, busy, TDC_Ovalid, TDC_Olast, TDC_Onum, TDC_Odata, TDC_Oint}), 0);
    rst = 1'b0;
    tick(2);

    // two hits, both kept in arrival order
    clear_obs();
    start_frame(10);
    hit(100, 4);
    hit(200, 9);
    wait_idle("t1");
    chk("t1_onum", int'(TDC_Onum), 2);
    chk("t1_nbeats", obs_tof.size(), 2);
    chk_beat("t1_b0", 0, 100, 4, 0);
    chk_beat("t1_b1", 1, 200, 9, 1);
    chk("t1_nstart", start_cyc.size(), 1);
    chk("t1_nirq", irq_cyc.size(), 1);

    // weakest slot replaced, weaker hit dropped when full
    clear_obs();
    start_frame(8);
    hit(10, 5);
    hit(20, 3);
    hit(30, 7);
    hit(40, 6);
    hit(50, 2);
    wait_idle("t2");
    chk("t2_onum", int'(TDC_Onum), 3);
    chk("t2_nbeats", obs_tof.size(), 3);
    chk_beat("t2_b0", 0, 10, 5, 0);
    chk_beat("t2_b1", 1, 40, 6, 0);
    chk_beat("t2_b2", 2, 30, 7, 1);

    // empty frame; the stray hit in IDLE must be ignored
    clear_obs();
    hit(99, 15);
    start_frame(4);
    wait_idle("t3");
    chk("t3_onum", int'(TDC_Onum), 0);
    chk("t3_nbeats", obs_tof.size(), 0);
    chk("t3_irq_gap", irq_gap(), 5);

    // back-pressure holds the first beat
    clear_obs();
    TDC_Oready = 1'b0;
    start_frame(6);
    hit(11, 7);
    hit(22, 8);
    wait_valid("t4");
    for (int i = 0; i < 8; i++) begin
      chk("t4_hold", int'({TDC_Ovalid, TDC_Odata, TDC_Oint, TDC_Olast}),
          int'({1'b1, 15'd11, 5'd7, 1'b0}));
      tick(1);
    end
    TDC_Oready = 1'b1;
    wait_idle("t4");
    chk("t4_nbeats", obs_tof.size(), 2);
    chk_beat("t4_b0", 0, 11, 7, 0);
    chk_beat("t4_b1", 1, 22, 8, 1);

    // reset in the middle of DRAIN, then a clean frame
    clear_obs();
    TDC_Oready = 1'b0;
    start_frame(3);
    hit(33, 3);
    hit(44, 4);
    wait_valid("t5");
    tick(2);
    rst = 1'b1;
    #1;
    chk("t5_rst_outputs",
        int'({tdc_start, TDC_INT, busy, TDC_Ovalid, TDC_Olast, TDC_Onum, TDC_Odata, TDC_Oint}), 0);
    tick(2);
    rst = 1'b0;
    TDC_Oready = 1'b1;
    clear_obs();
    start_frame(5);
    hit(55, 1);
    wait_idle("t5");
    chk("t5_onum", int'(TDC_Onum), 1);
    chk("t5_nbeats", obs_tof.size(), 1);
    chk_beat("t5_b0", 0, 55, 1, 1);

    // window_len=0 acts as a single window cycle
    clear_obs();
    start_frame(0);
    hit(5, 2);
    wait_idle("t6");
    chk("t6_nbeats", obs_tof.size(), 1);
    chk_beat("t6_b0", 0, 5, 2, 1);
    chk("t6_irq_gap", irq_gap(), 3);

    // frame_en held high: one IDLE cycle between frames
    clear_obs();
    window_len = 2;
    frame_en = 1'b1;
    for (int n = 0; n < 40 && start_cyc.size() < 2; n++) tick(1);
    frame_en = 1'b0;
    wait_idle("t7");
    chk("t7_nstart", start_cyc.size(), 2);
    if (start_cyc.size() >= 2) chk("t7_spacing", start_cyc[1] - start_cyc[0], 5);

`ifdef TDC_MIN_INT_EN
    // hits below min_int never reach the slots
    clear_obs();
    min_int = 4;
    start_frame(5);
    hit(60, 3);
    hit(70, 4);
    wait_idle("t8");
    chk("t8_onum", int'(TDC_Onum), 1);
    chk("t8_nbeats", obs_tof.size(), 1);
    chk_beat("t8_b0", 0, 70, 4, 1);
    min_int = 0;
`endif

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
